q2a03_oam_dma: RTL
==================

# q2a03_oam_dma

Sprite-DMA engine sitting directly downstream of the Q2A03 CPU core on the system bus. It snoops CPU writes to $4014 and halts the core via `G_ready`. It then takes over the bus and copies one 256-byte page from CPU address space to the OAM data port ($2004) as alternating get/put cycles, matching 2A03 cycle counts. When idle, the CPU bus passes through untouched.

## Interface
- `DMA_REG_ADDR`, 16'h4014, CPU write address that triggers DMA.
- `OAM_DATA_ADDR`, 16'h2004, destination address for every put cycle.
- `G_clock`  in  1  system clock, same clock as the CPU core.
- `G_reset`  in  1  reset; one clock, synchronous, active-high.
- `cpu_ce`  in  1  one-clock strobe marking each CPU cycle boundary (phy2 falling edge).
- `C_addr`  in  16  CPU address.
- `C_wr_data`  in  8  CPU write data.
- `C_rdwr`  in  1  CPU R/W (1 = read).
- `G_ready`  out  1  to CPU; 0 halts the core on its next read cycle.
- `B_addr`  out  16  system bus address (mux of CPU/DMA).
- `B_wr_data`  out  8  system bus write data.
- `B_rdwr`  out  1  system bus R/W.
- `B_rd_data`  in  8  system bus read data.
- `dma_busy`  out  1  high from trigger until the last put cycle completes.

## Operation
- States: IDLE, HALT, ALIGN, GET, PUT.
- All state, counter, parity and data registers update only on clocks with `cpu_ce`=1. `G_reset` overrides.
- `parity` flop toggles on every `cpu_ce`. It is 0 after reset. Cycles with `parity`=0 are get cycles; cycles with `parity`=1 are put cycles.
- IDLE: `G_ready`=1, bus = CPU. At `cpu_ce` with `C_rdwr`=0 and `C_addr`==`DMA_REG_ADDR`:
  - latch `page`<=`C_wr_data` and `idx`<=0;
  - `G_ready`<=0, `dma_busy`<=1, go to HALT.
- HALT: bus stays with CPU, which performs its dummy read. At `cpu_ce`:
  - if `C_rdwr`=0, the CPU is still writing; stay in HALT.
  - otherwise, the halt cycle is consumed. Go to GET if the next cycle is a get cycle, else go to ALIGN.
- ALIGN: one dummy CPU read cycle; then go to GET.
- GET: DMA drives `B_addr`={`page`,`idx`}, `B_rdwr`=1. At `cpu_ce`, latch `data`<=`B_rd_data` and go to PUT.
- PUT: DMA drives `B_addr`=`OAM_DATA_ADDR`, `B_rdwr`=0, `B_wr_data`=`data`. At `cpu_ce`:
  - `idx`<=`idx`+1, 8-bit wrap.
  - if `idx`==255, go to IDLE with `G_ready`<=1 and `dma_busy`<=0; else go to GET.
- Bus ownership: DMA owns the bus only in GET and PUT. In all other states `B_*` equals `C_*` combinationally.
- A write to `DMA_REG_ADDR` while not IDLE is ignored.

## Timing
- Reset values: state IDLE, `G_ready`=1, `dma_busy`=0, `parity`=0, `idx`=0, `page`=0, `data`=0. `B_*` follows the CPU pass-through.
- `G_ready`, `dma_busy` and state are registered. `B_*` is a combinational mux off the registered state.
- Duration, counted from the CPU cycle after the trigger write until `G_ready` returns high:
  - 513 CPU cycles when the halt ends on a put parity (no ALIGN);
  - 514 CPU cycles when ALIGN is inserted;
  - plus 1 per consecutive CPU write cycle that follows the trigger.
- Reset mid-transfer: on the next clock, return to IDLE, release the bus and drive `G_ready`=1. No partial resume.
- Clocks with `cpu_ce`=0 never change state, even if the `C_*` inputs toggle.

## Structure
- Shared `q2a03_pkg`: `dma_state_t` enum, the $4014/$2004 address constants, and `reg8_type`/`reg16_type` typedefs shared with the CPU core.
- Sub-module `q2a03_bus_mux`: pure 2:1 CPU/DMA mux for `B_addr`/`B_wr_data`/`B_rdwr`, selected by `dma_own`. It is reused by the future APU DMC fetch path.

## Test plan
- CPU writes $02 to $4014 with parity even after the halt. Required response:
  - GET reads $0200..$02FF;
  - 256 writes to $2004 with matching data;
  - `G_ready` low for exactly 513 cycles.
- Same trigger arranged so the halt ends on the opposite parity -> one ALIGN cycle; `G_ready` low for 514 cycles.
- Trigger followed by 2 CPU write cycles (JSR-style push) -> HALT held 2 extra cycles; DMA starts only after the first CPU read.
- Second $4014 write attempted mid-transfer (forced on `C_*`) -> ignored; `page` unchanged; total count unchanged.
- `G_reset` asserted at GET of `idx`=$80 -> next clock: IDLE, `G_ready`=1, bus equals CPU. A fresh trigger with `page`=$03 then completes cleanly from $0300.
- Non-trigger writes to $4013/$4015 and a read of $4014 -> no DMA; `dma_busy` stays 0.

Source files
------------

// File: rtl/q2a03_pkg.sv
// Shared Q2A03 types and bus constants, used by the CPU core and its bus-side
// peripherals.
package q2a03_pkg;

  typedef logic [7:0]  reg8_type;
  typedef logic [15:0] reg16_type;

  localparam reg16_type DMA_REG_ADDR  = 16'h4014;
  localparam reg16_type OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_GET,
    DMA_PUT
  } dma_state_t;

endpackage

// File: rtl/q2a03_bus_mux.sv
// 2:1 system-bus mux between the CPU and a DMA master; purely combinational so
// the bus follows the CPU in the same cycle whenever the DMA is not the owner.
module q2a03_bus_mux #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              dma_own,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              cpu_rdwr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wr_data,
  input  logic              dma_rdwr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  output logic              bus_rdwr
);

  assign bus_addr    = dma_own ? dma_addr    : cpu_addr;
  assign bus_wr_data = dma_own ? dma_wr_data : cpu_wr_data;
  assign bus_rdwr    = dma_own ? dma_rdwr    : cpu_rdwr;

endmodule

// File: rtl/q2a03_oam_dma.sv
// Sprite DMA: a CPU write to $4014 halts the core and copies one 256-byte page
// to $2004 as alternating get/put CPU cycles.
module q2a03_oam_dma
  import q2a03_pkg::*;
(
  input  logic      G_clock,
  input  logic      G_reset,
  input  logic      cpu_ce,
  input  reg16_type C_addr,
  input  reg8_type  C_wr_data,
  input  logic      C_rdwr,
  output logic      G_ready,
  output reg16_type B_addr,
  output reg8_type  B_wr_data,
  output logic      B_rdwr,
  input  reg8_type  B_rd_data,
  output logic      dma_busy
);

  dma_state_t state, state_nxt;
  logic       parity;
  reg8_type   page, page_nxt;
  reg8_type   idx, idx_nxt;
  reg8_type   data, data_nxt;
  logic       ready_nxt, busy_nxt;

  logic       dma_own;
  reg16_type  dma_addr;
  logic       dma_rdwr;

  always_ff @(posedge G_clock) begin
    if (G_reset) begin
      state    <= DMA_IDLE;
      parity   <= 1'b0;
      page     <= '0;
      idx      <= '0;
      data     <= '0;
      G_ready  <= 1'b1;
      dma_busy <= 1'b0;
    end else if (cpu_ce) begin
      state    <= state_nxt;
      parity   <= ~parity;
      page     <= page_nxt;
      idx      <= idx_nxt;
      data     <= data_nxt;
      G_ready  <= ready_nxt;
      dma_busy <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    page_nxt  = page;
    idx_nxt   = idx;
    data_nxt  = data;
    ready_nxt = G_ready;
    busy_nxt  = dma_busy;
    case (state)
      DMA_IDLE: begin
        if (!C_rdwr && (C_addr == DMA_REG_ADDR)) begin
          page_nxt  = C_wr_data;
          idx_nxt   = '0;
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = DMA_HALT;
        end
      end
      DMA_HALT: begin
        // The CPU only stops on a read; the next cycle has parity ~parity.
        if (C_rdwr) begin
          state_nxt = parity ? DMA_GET : DMA_ALIGN;
        end
      end
      DMA_ALIGN: begin
        state_nxt = DMA_GET;
      end
      DMA_GET: begin
        data_nxt  = B_rd_data;
        state_nxt = DMA_PUT;
      end
      DMA_PUT: begin
        idx_nxt = idx + 8'd1;
        if (idx == 8'hFF) begin
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = DMA_IDLE;
        end else begin
          state_nxt = DMA_GET;
        end
      end
      default: begin
        state_nxt = DMA_IDLE;
      end
    endcase
  end

  assign dma_own  = (state == DMA_GET) || (state == DMA_PUT);
  assign dma_rdwr = (state == DMA_GET);
  assign dma_addr = (state == DMA_GET) ? {page, idx} : OAM_DATA_ADDR;

  q2a03_bus_mux #(
    .ADDR_W(16),
    .DATA_W(8)
  ) u_bus_mux (
    .dma_own    (dma_own),
    .cpu_addr   (C_addr),
    .cpu_wr_data(C_wr_data),
    .cpu_rdwr   (C_rdwr),
    .dma_addr   (dma_addr),
    .dma_wr_data(data),
    .dma_rdwr   (dma_rdwr),
    .bus_addr   (B_addr),
    .bus_wr_data(B_wr_data),
    .bus_rdwr   (B_rdwr)
  );

endmodule
